// File: rtl/kbd_pkg.sv
// Shared keyboard types and default typematic timing for the 25.125 MHz system clock.
package kbd_pkg;

  typedef logic [7:0] key_code_t;

  localparam key_code_t NO_KEY = 8'h00;

  // 500 ms first-repeat delay and ~30 Hz repeat rate at 25.125 MHz
  localparam int KBD_REPEAT_DELAY = 12562500;
  localparam int KBD_REPEAT_RATE  = 837500;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with sticky overflow flag; head entry is read combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop on a full FIFO frees the head slot in the same cycle, so the push may take it.
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/key_event_queue.sv
// Turns the held-key word into press and typematic repeat events and queues them for the CPU.
module key_event_queue
  import kbd_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int REPEAT_DELAY = KBD_REPEAT_DELAY,
  parameter int REPEAT_RATE  = KBD_REPEAT_RATE
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] key_in,
  input  logic        pop,
  input  logic        clear,
  output logic [15:0] data_out,
  output logic        empty,
  output logic        full,
  output logic        overflow,
  output rep_state_t  dbg_state
);

  // pop and clear are single-cycle strobes with no ready: a pop on an empty queue
  // is ignored, and an event arriving at a full queue without a pop is dropped.

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  key_code_t        key;
  key_code_t        prev_key;
  key_code_t        push_data;
  key_code_t        head;
  logic             press;
  logic             push;
  rep_state_t       state_q;
  rep_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             unused_hi;

  assign key       = key_in[7:0];
  assign unused_hi = ^key_in[15:8];
  assign press     = (key != NO_KEY) && (key != prev_key);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_key <= NO_KEY;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
    end else begin
      prev_key <= key;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_data = key;
    case (state_q)
      ST_IDLE: begin
        if (press) begin
          push    = 1'b1;
          cnt_d   = '0;
          state_d = ST_DELAY;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (key == NO_KEY) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (press) begin
          // A new code restarts the delay, so a repeat never coincides with a press.
          push    = 1'b1;
          cnt_d   = '0;
          state_d = ST_DELAY;
        end else if (cnt_q == ((state_q == ST_DELAY) ? DELAY_LAST : RATE_LAST)) begin
          push      = 1'b1;
          push_data = prev_key;
          cnt_d     = '0;
          state_d   = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear     (clear),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

  assign data_out = {8'h00, head};

endmodule

// File: tb/tb_key_event_queue.sv
// Randomised and directed bench for key_event_queue against a hold-age event model.
module tb_key_event_queue;
  import kbd_pkg::*;

  localparam int DEPTH = 4;
  localparam int RD    = 20;
  localparam int RR    = 5;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] key_in;
  logic        pop;
  logic        clear;
  logic [15:0] data_out;
  logic        empty;
  logic        full;
  logic        overflow;
  rep_state_t  dbg_state;

  key_event_queue #(
    .DEPTH        (DEPTH),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .key_in    (key_in),
    .pop       (pop),
    .clear     (clear),
    .data_out  (data_out),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] m_prev;
  int         m_age;
  logic       m_ovf;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_prev = 8'h00;
    m_age  = 0;
    m_ovf  = 1'b0;
  endtask

  // A held code produces an event when first seen, again RD cycles later, then every RR cycles.
  task automatic model_step(input logic [7:0] k, input logic p, input logic c);
    logic       ev;
    logic       was_full;
    logic       popped;
    ev = 1'b0;
    if (k != 8'h00 && k != m_prev) begin
      ev    = 1'b1;
      m_age = 0;
    end else if (k != 8'h00) begin
      m_age++;
      if (m_age >= RD && ((m_age - RD) % RR) == 0) ev = 1'b1;
    end else begin
      m_age = 0;
    end
    m_prev = k;
    if (c) begin
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      was_full = (exp_q.size() == DEPTH);
      popped   = p && (exp_q.size() > 0);
      if (popped) void'(exp_q.pop_front());
      if (ev) begin
        if (was_full && !popped) m_ovf = 1'b1;
        else exp_q.push_back(k);
      end
    end
  endtask

  function automatic rep_state_t exp_state();
    if (m_prev == 8'h00) return ST_IDLE;
    if (m_age < RD) return ST_DELAY;
    return ST_REPEAT;
  endfunction

  task automatic check_outputs(input string tag);
    logic [15:0] exp_d;
    exp_d = (exp_q.size() > 0) ? {8'h00, exp_q[0]} : 16'h0000;
    chk({tag, "_data_out"}, 32'(data_out), 32'(exp_d));
    chk({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
    chk({tag, "_full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    chk({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, "_state"}, 32'(dbg_state), 32'(exp_state()));
  endtask

  // Monitor: compare whatever the DUT presents against the scoreboard head on every falling edge.
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) check_outputs("mon");
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [7:0] k, input logic p, input logic c);
    key_in = {8'($urandom_range(0, 255)), k};
    pop    = p;
    clear  = c;
    @(posedge clk);
    model_step(k, p, c);
    #1;
  endtask

  task automatic hold(input logic [7:0] k, input int n);
    for (int i = 0; i < n; i++) cycle(k, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(posedge clk);
    @(posedge clk);
    #2;
    resetn = 1'b1;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] keys [4];
    keys[0] = 8'h00; keys[1] = 8'h61; keys[2] = 8'h62; keys[3] = 8'h41;
    resetn = 1'b0;
    key_in = 16'h0000;
    pop    = 1'b0;
    clear  = 1'b0;
    model_reset();
    #12;
    mon_en = 1'b1;
    do_reset();

    // idle
    hold(8'h00, 50);
    // single tap then pop
    hold(8'h61, 3);
    hold(8'h00, 2);
    cycle(8'h00, 1'b1, 1'b0);
    hold(8'h00, 2);
    // auto-repeat to full, then overflow, then clear
    hold(8'h41, 31);
    chk("repeat_full", 32'(full), 32'd1);
    hold(8'h41, 5);
    chk("overflow_set", 32'(overflow), 32'd1);
    hold(8'h00, 3);
    cycle(8'h00, 1'b0, 1'b1);
    chk("clear_empty", 32'(empty), 32'd1);
    // key change mid-hold
    hold(8'h61, 10);
    hold(8'h62, 10);
    hold(8'h00, 1);
    chk("change_head", 32'(data_out), 32'h61);
    cycle(8'h00, 1'b1, 1'b0);
    chk("change_second", 32'(data_out), 32'h62);
    cycle(8'h00, 1'b1, 1'b0);
    // push+pop at full, then async reset mid-hold
    hold(8'h41, 35);
    cycle(8'h41, 1'b1, 1'b0);
    chk("pushpop_full", 32'(full), 32'd1);
    chk("pushpop_ovf", 32'(overflow), 32'd0);
    hold(8'h41, 3);
    do_reset();
    hold(8'h41, 2);
    chk("post_reset_event", 32'(data_out), 32'h41);
    cycle(8'h00, 1'b0, 1'b1);

    // randomised segments of held keys with random pops and rare clears
    for (int s = 0; s < 70; s++) begin
      logic [7:0] k;
      int         n;
      k = keys[$urandom_range(0, 3)];
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++)
        cycle(k, ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0));
    end
    // drain
    for (int i = 0; i < DEPTH + 1; i++) cycle(8'h00, 1'b1, 1'b0);
    chk("drained", 32'(empty), 32'd1);

    @(negedge clk);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Sits directly downstream of the PS/2 keyboard decoder; consumes its 16-bit "currently held key" word (ASCII in bits [7:0], zero = no key).
- Converts the level-style held-key word into discrete key-press events.
- Generates typematic auto-repeat while a key stays held.
- Buffers events in a small FIFO that the Hack CPU drains through a memory-mapped pop strobe, so fast typing is not lost between CPU polls.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- REPEAT_DELAY, 12562500, cycles from first press to first repeat (500 ms at 25.125 MHz).
- REPEAT_RATE, 837500, cycles between subsequent repeats (about 30 Hz).

Ports:
- clk  in  1  system clock, 25.125 MHz.
- resetn  in  1  asynchronous active-low reset.
- key_in  in  16  held-key word from the keyboard decoder; only [7:0] are significant, [15:8] are ignored.
- pop  in  1  one-cycle strobe; removes the head entry.
- clear  in  1  one-cycle strobe; flushes the FIFO and clears overflow.
- data_out  out  16  {8'b0, head ASCII}; 16'h0000 when empty.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds DEPTH entries.
- overflow  out  1  sticky; an event was dropped.

Behaviour:
- Reset (async, resetn=0):
  - FIFO is emptied and pointers are zeroed.
  - prev_key=0, repeat counter=0, state=IDLE, overflow=0.
  - Outputs: data_out=0, empty=1, full=0.
- Sampling: key_in[7:0] is compared combinationally against the registered prev_key. prev_key <= key_in[7:0] on every edge.
- Press event: key_in[7:0]!=0 and key_in[7:0]!=prev_key. The push happens on the same edge, so data_out and empty update after that edge (1-cycle latency).
- Repeat state machine:
  - IDLE: on a press event, go to DELAY with counter=0.
  - DELAY:
    - key_in[7:0]==0: go to IDLE.
    - A new different code: push it and restart DELAY with counter=0.
    - Counter reaches REPEAT_DELAY-1: push prev_key, counter=0, go to REPEAT.
    - Otherwise: counter+1.
  - REPEAT:
    - Release and change are handled as in DELAY.
    - Counter reaches REPEAT_RATE-1: push prev_key, counter=0, stay in REPEAT.
  - Counter width is $clog2(max(REPEAT_DELAY,REPEAT_RATE)).
- At most one push per cycle. A press event takes priority; a repeat push and a press event cannot coincide because a press restarts the counter.
- FIFO:
  - Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
  - full when the pointers differ only in the MSB; empty when they are equal.
- pop while empty: ignored; pointers are unchanged.
- Push while full:
  - Without a pop in the same cycle: the entry is dropped and overflow<=1.
  - With a pop in the same cycle: both occur, occupancy stays DEPTH, no overflow.
- Simultaneous push and pop when not full or empty: both occur, occupancy is unchanged.
- clear: empties the FIFO and sets overflow<=0.
  - clear has priority over a push or pop in the same cycle; both are discarded.
  - clear does not affect the repeat state or prev_key.
- data_out is a combinational read of the head entry, gated to 0 when empty.
- A key released and re-pressed with at least one cycle of 0 between produces two events.
- A code held across reset produces one new event after reset deasserts, because prev_key resets to 0.

Decomposition:
- Shared package kbd_pkg:
  - NO_KEY = 8'h00.
  - Default REPEAT_DELAY / REPEAT_RATE constants for 25.125 MHz.
  - Typedef key_code_t = logic [7:0].
- Sub-module sync_fifo:
  - Parameterised by WIDTH=8 and DEPTH.
  - Handles push/pop/clear, full/empty and the overflow flag.
- The parent holds the edge detector and the repeat FSM.

Test Plan (sim overrides REPEAT_DELAY=20, REPEAT_RATE=5, DEPTH=4):
- Reset then idle: key_in=0 for 50 cycles -> empty=1, data_out=0, overflow=0 throughout.
- Single tap: key_in=16'h0061 for 3 cycles, then 0 -> exactly one entry; data_out=16'h0061 one cycle after the first sample; pop -> empty=1.
- Auto-repeat: hold 16'h0041 for 31 cycles (no pops) -> pushes at cycles 0, 20, 25, 30; the FIFO ends full with four 'A' entries and overflow=0.
- Overflow: hold 16'h0041 for 36 cycles (no pops) -> fifth push at cycle 35 is dropped; overflow=1 and stays 1 until clear; clear -> empty=1, overflow=0.
- Key change mid-hold: 16'h0061 for 10 cycles, then 16'h0062 for 10 cycles -> entries 'a','b' only; no repeat, because the counter restarted on the change.
- Push+pop at full: FIFO full; pop in the same cycle a repeat push fires -> occupancy stays 4, overflow=0, head advances one entry; async reset mid-hold -> all outputs return to reset values immediately.
